// File: rtl/polyphase_ts_ctrl.sv
// Slot sequencer for the time-shared polyphase interpolating transmit filter.
// Optional saturating error counter enabled by defining TS_CTRL_ERR_CNT_EN.
module polyphase_ts_ctrl #(
  parameter int UPSAMPLE  = 4,
  parameter int NUM_STEPS = 3,
  parameter int ERR_CNT_W = 16,
  localparam int PW = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int CW = (UPSAMPLE * NUM_STEPS > 1) ? $clog2(UPSAMPLE * NUM_STEPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sam_clk_en,
  input  logic                 sym_clk_en,
  output logic                 shift_en,
  output logic [PW-1:0]        phase,
  output logic [SW-1:0]        step,
  output logic [CW-1:0]        coef_addr,
  output logic                 mac_en,
  output logic                 acc_clr,
  output logic                 y_load,
  output logic                 locked,
  output logic                 overrun,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, MAC, DUMP} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  step_q, step_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [PW-1:0]  phase_cnt_q, phase_cnt_d;
  logic [CW-1:0]  coef_addr_q, coef_addr_d;
  logic           mac_en_q, mac_en_d;
  logic           acc_clr_q, acc_clr_d;
  logic           y_load_q, y_load_d;
  logic           locked_q, locked_d;
  logic           overrun_q, overrun_d;
  logic           sync_err_q, sync_err_d;

  // Delay line must shift on the same edge that launches the first MAC slot.
  assign shift_en = sam_clk_en & sym_clk_en & reset;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    phase_d     = phase_q;
    phase_cnt_d = phase_cnt_q;
    locked_d    = locked_q;
    mac_en_d    = 1'b0;
    acc_clr_d   = 1'b0;
    y_load_d    = 1'b0;
    overrun_d   = 1'b0;
    sync_err_d  = 1'b0;

    if (sam_clk_en) begin
      if (sym_clk_en) begin
        phase_d     = '0;
        phase_cnt_d = PW'(1);
        locked_d    = 1'b1;
        sync_err_d  = locked_q && (phase_cnt_q != '0);
      end else begin
        phase_d     = phase_cnt_q;
        phase_cnt_d = (phase_cnt_q == PW'(UPSAMPLE - 1)) ? '0 : phase_cnt_q + PW'(1);
      end
    end

    // A new sample always restarts at slot 0; arriving mid-MAC discards the partial sum.
    if (sam_clk_en) begin
      overrun_d = (state_q == MAC);
      state_d   = MAC;
      step_d    = '0;
      mac_en_d  = 1'b1;
      acc_clr_d = 1'b1;
    end else begin
      unique case (state_q)
        MAC: begin
          if (step_q == SW'(NUM_STEPS - 1)) begin
            state_d  = DUMP;
            step_d   = '0;
            y_load_d = 1'b1;
          end else begin
            step_d   = step_q + SW'(1);
            mac_en_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end

    coef_addr_d = CW'(phase_d) * CW'(NUM_STEPS) + CW'(step_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      phase_q     <= '0;
      phase_cnt_q <= '0;
      coef_addr_q <= '0;
      mac_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      y_load_q    <= 1'b0;
      locked_q    <= 1'b0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      phase_cnt_q <= phase_cnt_d;
      coef_addr_q <= coef_addr_d;
      mac_en_q    <= mac_en_d;
      acc_clr_q   <= acc_clr_d;
      y_load_q    <= y_load_d;
      locked_q    <= locked_d;
      overrun_q   <= overrun_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign phase     = phase_q;
  assign step      = step_q;
  assign coef_addr = coef_addr_q;
  assign mac_en    = mac_en_q;
  assign acc_clr   = acc_clr_q;
  assign y_load    = y_load_q;
  assign locked    = locked_q;
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

`ifdef TS_CTRL_ERR_CNT_EN
  localparam int EW = ERR_CNT_W + 1;

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [EW-1:0]        err_sum;

  // One extra bit catches wrap so the count pins at all-ones.
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + EW'(overrun_q) + EW'(sync_err_q);
    err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_polyphase_ts_ctrl.sv
// Directed bench for polyphase_ts_ctrl (UPSAMPLE=4, NUM_STEPS=3, ERR_CNT_W=3).
// err_cnt expectations follow whether TS_CTRL_ERR_CNT_EN is defined.
module tb_polyphase_ts_ctrl;

`ifdef TS_CTRL_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       sam_clk_en;
  logic       sym_clk_en;
  logic       shift_en;
  logic [1:0] phase;
  logic [1:0] step;
  logic [3:0] coef_addr;
  logic       mac_en;
  logic       acc_clr;
  logic       y_load;
  logic       locked;
  logic       overrun;
  logic       sync_err;
  logic [2:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  // {mac_en, acc_clr, y_load, overrun, sync_err, locked, phase, step, coef_addr}
  logic [13:0] obs;
  assign obs = {mac_en, acc_clr, y_load, overrun, sync_err, locked, phase, step, coef_addr};

  polyphase_ts_ctrl #(.UPSAMPLE(4), .NUM_STEPS(3), .ERR_CNT_W(3)) dut (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .shift_en(shift_en), .phase(phase), .step(step), .coef_addr(coef_addr),
    .mac_en(mac_en), .acc_clr(acc_clr), .y_load(y_load), .locked(locked),
    .overrun(overrun), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample from strobe through its DUMP cycle; returns in the DUMP cycle.
  task automatic run_sample(input string tag, input bit sym, input int exp_phase,
                            input bit exp_sync, input bit exp_locked);
    logic [13:0] exp;
    sam_clk_en = 1'b1;
    sym_clk_en = sym;
    #1;
    checks++;
    if (shift_en !== sym) begin
      failures++;
      $display("FAIL %s_shift_en: got %b expected %b", tag, shift_en, sym);
    end
    tick();
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      exp = {1'b1, (s == 0), 1'b0, 1'b0, (s == 0) & exp_sync, exp_locked,
             2'(exp_phase), 2'(s), 4'(exp_phase * 3 + s)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s_slot%0d: got %h expected %h", tag, s, obs, exp);
      end
      tick();
    end
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_locked, 2'(exp_phase), 2'd0, 4'(exp_phase * 3)};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s_dump: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 14'd0 || shift_en !== 1'b0 || err_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got %h/%b/%0d expected 0/0/0", obs, shift_en, err_cnt);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    for (int k = 0; k < 12; k++) begin
      run_sample("nominal", (k % 4) == 0, k % 4, 1'b0, 1'b1);
    end
    tick();
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 4'd9}) begin
      failures++;
      $display("FAIL nominal_idle: got %h expected %h", obs,
               {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 4'd9});
    end
  endtask

  task automatic test_misalign();
    run_sample("mis_a", 1'b1, 0, 1'b0, 1'b1);
    run_sample("mis_b", 1'b0, 1, 1'b0, 1'b1);
    run_sample("mis_c", 1'b1, 0, 1'b1, 1'b1);
    run_sample("mis_d", 1'b0, 1, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_overrun();
    logic [13:0] exp_tab [6];
    exp_tab[0] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 4'd9};
    exp_tab[0][12] = 1'b1;
    exp_tab[1] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1, 4'd10};
    exp_tab[2] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 4'd11};
    exp_tab[3] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 4'd9};
    exp_tab[4] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 4'd9};
    exp_tab[5] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 4'd6};
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    checks++;
    if (obs !== exp_tab[5]) begin
      failures++;
      $display("FAIL ovr_first: got %h expected %h", obs, exp_tab[5]);
    end
    tick();
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== exp_tab[c]) begin
        failures++;
        $display("FAIL ovr_cycle%0d: got %h expected %h", c, obs, exp_tab[c]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    run_sample("b2b_a", 1'b1, 0, 1'b0, 1'b1);
    run_sample("b2b_b", 1'b0, 1, 1'b0, 1'b1);
    tick();
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 4'd3}) begin
      failures++;
      $display("FAIL b2b_idle: got %h expected %h", obs,
               {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 4'd3});
    end
  endtask

  task automatic test_reset_mid();
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 4'd7}) begin
      failures++;
      $display("FAIL rstmid_pre: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 4'd7});
    end
    reset = 1'b0;
    sam_clk_en = 1'b1;
    sym_clk_en = 1'b1;
    #1;
    checks++;
    if (obs !== 14'd0 || shift_en !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: got %h/%b expected 0/0", obs, shift_en);
    end
    tick();
    tick();
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== 14'd0) begin
      failures++;
      $display("FAIL rstmid_idle: got %h expected 0", obs);
    end
    run_sample("rstmid", 1'b0, 0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_err_cnt();
    bit sym_pat [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      sam_clk_en = 1'b1;
      sym_clk_en = sym_pat[i];
      tick();
      sam_clk_en = 1'b0;
      sym_clk_en = 1'b0;
      if (i == 1) begin
        checks++;
        if (overrun !== 1'b1 || sync_err !== 1'b1) begin
          failures++;
          $display("FAIL err_both_pulse: got %b%b expected 11", overrun, sync_err);
        end
      end
      tick();
      if (i == 3) begin
        checks++;
        if (err_cnt !== (ERR_EN ? 3'd5 : 3'd0)) begin
          failures++;
          $display("FAIL err_cnt_five: got %0d expected %0d", err_cnt, ERR_EN ? 5 : 0);
        end
      end
    end
    checks++;
    if (err_cnt !== (ERR_EN ? 3'd7 : 3'd0)) begin
      failures++;
      $display("FAIL err_cnt_sat: got %0d expected %0d", err_cnt, ERR_EN ? 7 : 0);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (err_cnt !== (ERR_EN ? 3'd7 : 3'd0)) begin
      failures++;
      $display("FAIL err_cnt_hold: got %0d expected %0d", err_cnt, ERR_EN ? 7 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_misalign();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_err_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
